// File: rtl/systolic_feeder_pkg.sv
// ============================================================================
// systolic_pkg : shared types for the systolic array input feeder
// Revision     : 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int c_data_w = 32;

    typedef struct packed {
        logic [c_data_w-1:0] col1;
        logic [c_data_w-1:0] col2;
    } row_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_fifo.sv
// ============================================================================
// feeder_fifo : synchronous FIFO with occupancy, power-of-2 depth
// Revision    : 1.0
// ============================================================================
`default_nettype none

module feeder_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign full  = (r_count == (c_addr_w+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_addr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder : row FIFO, one-cycle column skew and frame tracking for
//                   the 2-column QR array. Option: SYSTOLIC_FEEDER_FRAME_CNT_EN
// Revision        : 1.0
// ============================================================================
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = 4,
    parameter int ROWS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_col1,
    input  logic [DATA_W-1:0] in_col2,
    output logic [DATA_W-1:0] x01,
    output logic [DATA_W-1:0] x02,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
`ifdef SYSTOLIC_FEEDER_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int                c_cnt_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(ROWS - 1);

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [2*DATA_W-1:0]     w_head;
    logic [$clog2(DEPTH):0]  w_count;

    logic [DATA_W-1:0]       r_skew;
    logic                    r_skew_vld;
    logic                    r_done_arm;
    logic [c_cnt_w-1:0]      r_row_cnt;
    frame_state_e            r_state;

    assign in_ready = !w_full;
    assign w_pop    = !w_empty;

    feeder_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata ({in_col1, in_col2}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign busy = (w_count != '0) || r_skew_vld || (r_state == STREAM);

    // An empty FIFO feeds zeros: the array treats a zero input as identity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x01         <= '0;
            x02         <= '0;
            r_skew      <= '0;
            r_skew_vld  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            r_done_arm  <= 1'b0;
            r_row_cnt   <= '0;
            r_state     <= IDLE;
        end else begin
            x02         <= r_skew;
            frame_done  <= r_done_arm;
            frame_start <= 1'b0;
            r_done_arm  <= 1'b0;
            if (w_pop) begin
                x01        <= w_head[2*DATA_W-1:DATA_W];
                r_skew     <= w_head[DATA_W-1:0];
                r_skew_vld <= 1'b1;
                if (r_state == IDLE) begin
                    frame_start <= 1'b1;
                end
                // Last row of the frame: frame_done lands one cycle later, with its x02.
                if (r_row_cnt == c_last) begin
                    r_done_arm <= 1'b1;
                    r_row_cnt  <= '0;
                    r_state    <= IDLE;
                end else begin
                    r_row_cnt  <= r_row_cnt + c_cnt_w'(1);
                    r_state    <= STREAM;
                end
            end else begin
                x01        <= '0;
                r_skew     <= '0;
                r_skew_vld <= 1'b0;
            end
        end
    end

`ifdef SYSTOLIC_FEEDER_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (r_done_arm) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// tb_systolic_feeder : vector table, random traffic vs queue model, corners
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ROWS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_col1;
    logic [DATA_W-1:0] in_col2;
    logic [DATA_W-1:0] x01;
    logic [DATA_W-1:0] x02;
    logic              frame_start;
    logic              frame_done;
    logic              busy;
`ifdef SYSTOLIC_FEEDER_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    always #5 clk = ~clk;

    systolic_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ROWS   (ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_col1     (in_col1),
        .in_col2     (in_col2),
        .x01         (x01),
        .x02         (x02),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
`ifdef SYSTOLIC_FEEDER_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of rows plus a count of rows delivered.
    row_t        q[$];
    logic [31:0] m_x01, m_x02, m_skew;
    bit          m_skew_vld, m_fs, m_fd, m_done_arm;
    int          m_popped;

    typedef struct {
        bit          vld;
        logic [31:0] c1, c2;
        logic [31:0] ex01, ex02;
        bit          efs, efd, ebusy, erdy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_x01 = 0; m_x02 = 0; m_skew = 0; m_skew_vld = 0;
        m_fs = 0; m_fd = 0; m_done_arm = 0; m_popped = 0;
    endtask

    task automatic m_edge();
        row_t h;
        bit   pop;
        bit   acc;
        pop   = (q.size() > 0);
        acc   = in_valid && (q.size() != DEPTH);
        m_x02 = m_skew;
        m_fd  = m_done_arm;
        if (pop) begin
            h          = q.pop_front();
            m_x01      = h.col1;
            m_skew     = h.col2;
            m_skew_vld = 1;
            m_fs       = (m_popped % ROWS == 0);
            m_done_arm = (m_popped % ROWS == ROWS - 1);
            m_popped++;
        end else begin
            m_x01 = 0; m_skew = 0; m_skew_vld = 0; m_fs = 0; m_done_arm = 0;
        end
        if (acc) q.push_back(row_t'{col1: in_col1, col2: in_col2});
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_col1 = a; in_col2 = b;
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("x01", x01, m_x01);
        chk("x02", x02, m_x02);
        chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        chk("busy", {31'd0, busy},
            {31'd0, (q.size() != 0) || m_skew_vld || (m_popped % ROWS != 0)});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != DEPTH});
    endtask

    initial begin
        int          fd_seen;
        logic [31:0] fd_x02;
        row_t        r;

        // Reset idle, then one frame {1,2},{3,4},{5,6},{7,8} and drain.
        for (int i = 0; i < 5; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 1, 2, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 3, 4, 1, 0, 1, 0, 1, 1};
        tbl[7]  = '{1, 5, 6, 3, 2, 0, 0, 1, 1};
        tbl[8]  = '{1, 7, 8, 5, 4, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 7, 6, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 8, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

        rst = 1'b1;
        drive(0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x01", x01, 0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].vld, tbl[i].c1, tbl[i].c2);
            step();
            chk("tbl_x01", x01, tbl[i].ex01);
            chk("tbl_x02", x02, tbl[i].ex02);
            chk("tbl_fs", {31'd0, frame_start}, {31'd0, tbl[i].efs});
            chk("tbl_fd", {31'd0, frame_done}, {31'd0, tbl[i].efd});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].ebusy});
            chk("tbl_ready", {31'd0, in_ready}, {31'd0, tbl[i].erdy});
        end

        // Held valid with rows 10..15, order checked by the model.
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'd10 + k, 32'd100 + k);
            step();
        end
        drive(0, 0, 0);
        repeat (4) step();

        // Random traffic with varying offered load.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) < ((i / 100) % 4)) || (i % 7 == 0), $urandom, $urandom);
            step();
        end

        // Drain, then reset between edges after row 2 of a frame.
        drive(0, 0, 0);
        repeat (8) step();
        if (m_popped % ROWS != 0) begin
            for (int k = m_popped % ROWS; k < ROWS; k++) begin
                drive(1, 32'h9000 + k, 32'h9100 + k);
                step();
            end
            drive(0, 0, 0);
            repeat (4) step();
        end
        for (int k = 1; k <= 3; k++) begin
            drive(1, 32'hA0 + k, 32'hB0 + k);
            step();
        end
        drive(0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x01", x01, 0);
        chk("arst_x02", x02, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_fs", {31'd0, frame_start}, 0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        // Underflow mid-frame: 2 rows, 3-cycle gap, 2 rows.
        fd_seen = 0;
        fd_x02  = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 2 || (c >= 5 && c < 7)) drive(1, 32'hC0 + c, 32'hD0 + c);
            else drive(0, 0, 0);
            step();
            if (c == 1) chk("new_frame_start", {31'd0, frame_start}, 32'd1);
            if (c == 1) chk("new_frame_x01", x01, 32'hC0);
            if (frame_done) begin
                fd_seen++;
                fd_x02 = x02;
            end
        end
        chk("underflow_done_count", fd_seen, 1);
        chk("underflow_done_x02", fd_x02, 32'hD6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
